data_mem_ctrl: RTL and testbench

Load/store sequencer between the CPU memory stage and the word-wide synchronous data memory. It accepts one RISC-V load or store request at a time: LB/LH/LW/LBU/LHU and SB/SH/SW. Sub-word stores run as read-modify-write over the 32-bit memory port, and loaded data is extracted and extended. Done, read data and fault are registered back to the requester.

---
 rtl/data_mem_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - load/store sequencer between the CPU memory stage and a word-wide synchronous data memory
//
// Handles one RISC-V load or store at a time (LB/LH/LW/LBU/LHU, SB/SH/SW).
// Sub-word stores run as read-modify-write on the 32-bit memory port.
// Loaded bytes and halves are extracted from the word and then extended.
// done, rdata and fault are registered back to the requester.
//
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned accesses.
//   - A trapped access never reaches memory.
//   - It completes with done=1 and fault=1, and rdata is left unchanged.
//   - With the macro undefined, fault stays 0 and the low address bits are
//     ignored: half uses addr[1], word uses lane 0.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   req                request strobe, sampled only while busy=0
//   we, funct3, addr   store flag, access type, byte address (latched on accept)
//   wdata              store data in the low bits (latched on accept)
//   busy               state is not IDLE
//   done               one-cycle completion pulse
//   rdata              last load result, held until the next load completes
//   fault              misalignment flag, valid with done
//   mem_addr           word address to memory
//   mem_we, mem_wdata  memory write strobe and write word
//   mem_rdata          memory read word, valid the cycle after mem_addr is sampled
module data_mem_ctrl #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req,
    input  logic                     we,
    input  logic [2:0]               funct3,
    input  logic [ADDRESS_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic                     fault,
    output logic [ADDRESS_WIDTH-3:0] mem_addr,
    output logic                     mem_we,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_WRITE,
        S_FAULT
    } state_t;

    state_t                     state_q;
    logic                       done_q;
    logic                       fault_q;
    logic [DATA_WIDTH-1:0]      rdata_q;
    logic [DATA_WIDTH-1:0]      merge_q;
    logic                       we_q;
    logic [2:0]                 funct3_q;
    logic [ADDRESS_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]      wdata_q;

    logic [DATA_WIDTH-1:0]      rdata_d;
    logic [DATA_WIDTH-1:0]      merge_d;
    logic [7:0]                 byte_sel;
    logic [15:0]                half_sel;
    logic                       misaligned;

    // Access size: funct3[1:0] 00=byte, 01=half, 1x=word; funct3[2] is the unsigned bit.
    logic                       is_byte_q;
    logic                       is_half_q;
    logic                       is_word_q;
    logic [1:0]                 off_q;

    assign is_byte_q = (funct3_q[1:0] == 2'b00);
    assign is_half_q = (funct3_q[1:0] == 2'b01);
    assign is_word_q = funct3_q[1];
    assign off_q     = addr_q[1:0];

    // Misalignment is decided on the incoming request, so a trapped access
    // never touches memory.
`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                        (funct3[1] && (addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Load extraction and store merge, both from the word returned by memory.
    always_comb begin
        byte_sel = mem_rdata[7:0];
        case (off_q)
            2'b01:   byte_sel = mem_rdata[15:8];
            2'b10:   byte_sel = mem_rdata[23:16];
            2'b11:   byte_sel = mem_rdata[31:24];
            default: byte_sel = mem_rdata[7:0];
        endcase
        half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        if (is_byte_q) begin
            rdata_d = funct3_q[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        end else if (is_half_q) begin
            rdata_d = funct3_q[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
        end else begin
            rdata_d = mem_rdata;
        end

        merge_d = mem_rdata;
        if (is_byte_q) begin
            case (off_q)
                2'b00:   merge_d[7:0]   = wdata_q[7:0];
                2'b01:   merge_d[15:8]  = wdata_q[7:0];
                2'b10:   merge_d[23:16] = wdata_q[7:0];
                default: merge_d[31:24] = wdata_q[7:0];
            endcase
        end else if (is_half_q) begin
            if (off_q[1]) begin
                merge_d[31:16] = wdata_q[15:0];
            end else begin
                merge_d[15:0]  = wdata_q[15:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
            rdata_q  <= '0;
            merge_q  <= '0;
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        we_q     <= we;
                        funct3_q <= funct3;
                        addr_q   <= addr;
                        wdata_q  <= wdata;
                        if (misaligned) begin
                            state_q <= S_FAULT;
                        end else if (we && funct3[1]) begin
                            // A full-word store needs no read, so it goes straight to WRITE.
                            state_q <= S_WRITE;
                        end else begin
                            state_q <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    state_q <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (!we_q) begin
                        rdata_q <= rdata_d;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        merge_q <= merge_d;
                        state_q <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                S_FAULT: begin
                    done_q  <= 1'b1;
                    fault_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign fault     = fault_q;
    assign mem_addr  = addr_q[ADDRESS_WIDTH-1:2];
    // Gated by rst so that a reset arriving during WRITE suppresses the store.
    assign mem_we    = (state_q == S_WRITE) && !rst;
    assign mem_wdata = is_word_q ? wdata_q : merge_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - table-driven self-checking bench for data_mem_ctrl
module tb_data_mem_ctrl;

    localparam int AW = 16;
`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic          we;
    logic [2:0]    funct3;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          busy;
    logic          done;
    logic [31:0]   rdata;
    logic          fault;
    logic [AW-3:0] mem_addr;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          preload;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .fault     (fault),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Synchronous word memory: read data valid the cycle after the address is sampled.
    logic [31:0] mem [0:(1<<(AW-2))-1];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[4] <= 32'h876543F1;
            mem[8] <= 32'h0BADF00D;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [15:0] addr;
        logic [31:0] wdata;
        int          lat;
        int          wes;
        logic        flt;
        logic [31:0] rd;
        logic        chk_mem;
        int          midx;
        logic [31:0] mval;
    } vec_t;

    localparam int NV = 19;
    vec_t tbl [0:NV-1];

    function automatic vec_t mk(input logic w, input logic [2:0] f, input logic [15:0] a,
                                input logic [31:0] d, input int l, input int ws, input logic fl,
                                input logic [31:0] r, input logic cm, input int mi,
                                input logic [31:0] mv);
        vec_t t;
        t.we = w; t.f3 = f; t.addr = a; t.wdata = d; t.lat = l; t.wes = ws;
        t.flt = fl; t.rd = r; t.chk_mem = cm; t.midx = mi; t.mval = mv;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Starts at a negedge, returns at the negedge of the done cycle, so
    // consecutive calls issue each request in the previous done cycle.
    task automatic run_vec(input vec_t t, input int idx);
        int   lat;
        int   wes;
        logic got;
        req = 1'b1; we = t.we; funct3 = t.f3; addr = t.addr; wdata = t.wdata;
        @(posedge clk);
        #1;
        req = 1'b0;
        check($sformatf("v%0d busy_after_accept", idx), {31'b0, busy}, 32'd1);
        got = 1'b0; lat = -1; wes = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (mem_we) wes++;
            if (done) begin
                got = 1'b1;
                lat = k;
            end
        end
        check($sformatf("v%0d latency", idx), 32'(lat), 32'(t.lat));
        check($sformatf("v%0d mem_we_cycles", idx), 32'(wes), 32'(t.wes));
        check($sformatf("v%0d fault", idx), {31'b0, fault}, {31'b0, t.flt});
        check($sformatf("v%0d rdata", idx), rdata, t.rd);
        check($sformatf("v%0d busy_in_done", idx), {31'b0, busy}, 32'd0);
        if (t.chk_mem) check($sformatf("v%0d mem_word", idx), mem[t.midx], t.mval);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   k;
        int   cnt_done;
        int   cnt_we;
        logic got;

        tbl[0]  = mk(0, 3'b000, 16'h0010, 32'h0,        2, 0, 0, 32'hFFFFFFF1, 0, 0, 0);
        tbl[1]  = mk(0, 3'b100, 16'h0013, 32'h0,        2, 0, 0, 32'h00000087, 0, 0, 0);
        tbl[2]  = mk(0, 3'b001, 16'h0012, 32'h0,        2, 0, 0, 32'hFFFF8765, 0, 0, 0);
        tbl[3]  = mk(0, 3'b101, 16'h0012, 32'h0,        2, 0, 0, 32'h00008765, 0, 0, 0);
        tbl[4]  = mk(0, 3'b010, 16'h0010, 32'h0,        2, 0, 0, 32'h876543F1, 0, 0, 0);
        tbl[5]  = mk(1, 3'b000, 16'h0011, 32'h123456AA, 3, 1, 0, 32'h876543F1, 1, 4, 32'h8765AAF1);
        tbl[6]  = mk(0, 3'b010, 16'h0010, 32'h0,        2, 0, 0, 32'h8765AAF1, 0, 0, 0);
        tbl[7]  = mk(1, 3'b010, 16'h0014, 32'hDEADBEEF, 1, 1, 0, 32'h8765AAF1, 1, 5, 32'hDEADBEEF);
        tbl[8]  = mk(0, 3'b010, 16'h0014, 32'h0,        2, 0, 0, 32'hDEADBEEF, 0, 0, 0);
        tbl[9]  = TRAP ? mk(0, 3'b010, 16'h0012, 32'h0, 1, 0, 1, 32'hDEADBEEF, 0, 0, 0)
                       : mk(0, 3'b010, 16'h0012, 32'h0, 2, 0, 0, 32'h8765AAF1, 0, 0, 0);
        tbl[10] = mk(1, 3'b001, 16'h0012, 32'h0000BEEF, 3, 1, 0,
                     TRAP ? 32'hDEADBEEF : 32'h8765AAF1, 1, 4, 32'hBEEFAAF1);
        tbl[11] = mk(0, 3'b000, 16'h0013, 32'h0,        2, 0, 0, 32'hFFFFFFBE, 0, 0, 0);
        tbl[12] = mk(0, 3'b001, 16'h0010, 32'h0,        2, 0, 0, 32'hFFFFAAF1, 0, 0, 0);
        tbl[13] = TRAP ? mk(0, 3'b101, 16'h0011, 32'h0, 1, 0, 1, 32'hFFFFAAF1, 0, 0, 0)
                       : mk(0, 3'b101, 16'h0011, 32'h0, 2, 0, 0, 32'h0000AAF1, 0, 0, 0);
        tbl[14] = mk(0, 3'b011, 16'h0014, 32'h0,        2, 0, 0, 32'hDEADBEEF, 0, 0, 0);
        tbl[15] = mk(1, 3'b100, 16'h0017, 32'h00000011, 3, 1, 0, 32'hDEADBEEF, 1, 5, 32'h11ADBEEF);
        tbl[16] = TRAP ? mk(0, 3'b110, 16'h0016, 32'h0, 1, 0, 1, 32'hDEADBEEF, 0, 0, 0)
                       : mk(0, 3'b110, 16'h0016, 32'h0, 2, 0, 0, 32'h11ADBEEF, 0, 0, 0);
        tbl[17] = mk(0, 3'b111, 16'h0014, 32'h0,        2, 0, 0, 32'h11ADBEEF, 0, 0, 0);
        tbl[18] = TRAP ? mk(1, 3'b010, 16'h0015, 32'hCAFEF00D, 1, 0, 1, 32'h11ADBEEF, 1, 5, 32'h11ADBEEF)
                       : mk(1, 3'b010, 16'h0015, 32'hCAFEF00D, 1, 1, 0, 32'h11ADBEEF, 1, 5, 32'hCAFEF00D);

        rst = 1'b1; preload = 1'b1; req = 1'b0; we = 1'b0; funct3 = 3'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy",   {31'b0, busy},   32'd0);
        check("reset_done",   {31'b0, done},   32'd0);
        check("reset_fault",  {31'b0, fault},  32'd0);
        check("reset_mem_we", {31'b0, mem_we}, 32'd0);
        check("reset_rdata",  rdata,           32'h0);
        rst = 1'b0; preload = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) run_vec(tbl[i], i);

        // done lasts exactly one cycle
        @(negedge clk);
        check("done_one_cycle", {31'b0, done}, 32'd0);
        check("idle_after_done", {31'b0, busy}, 32'd0);

        // req pulsed while busy is ignored: LW 0x10, then a SW attempt during READ
        req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 16'h0010; wdata = 32'h0;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        req = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 16'h0020; wdata = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        req = 1'b0;
        got = 1'b0; k = 1;
        while (!got && k < 10) begin
            @(negedge clk);
            if (done) got = 1'b1;
            else k++;
        end
        check("busy_req_latency", 32'(k), 32'd2);
        check("busy_req_rdata", rdata, 32'hBEEFAAF1);
        cnt_done = 0; cnt_we = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) cnt_done++;
            if (mem_we) cnt_we++;
        end
        check("busy_req_no_second_done", 32'(cnt_done), 32'd0);
        check("busy_req_no_write", 32'(cnt_we), 32'd0);
        check("busy_req_mem8", mem[8], 32'h0BADF00D);

        // rst during WRITE of SH 0x0010 suppresses the write
        req = 1'b1; we = 1'b1; funct3 = 3'b001; addr = 16'h0010; wdata = 32'h00001234;
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (3) @(negedge clk);
        check("rmw_write_state_we", {31'b0, mem_we}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_gates_mem_we", {31'b0, mem_we}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_mid_busy",  {31'b0, busy},  32'd0);
        check("rst_mid_done",  {31'b0, done},  32'd0);
        check("rst_mid_rdata", rdata,          32'h0);
        check("rst_mid_mem4",  mem[4],         32'hBEEFAAF1);
        rst = 1'b0;
        @(negedge clk);
        run_vec(mk(0, 3'b010, 16'h0010, 32'h0, 2, 0, 0, 32'hBEEFAAF1, 0, 0, 0), NV);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
